// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl : pipeline hazard FSM (load-use, mispredict, syscall, imiss)
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int SYS_MIN_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Mispredict_EX,
  input  logic [31:0] Mispredict_PC_EX,
  input  logic        Syscall_ID,
  input  logic        Syscall_Done_WB,
  input  logic        Load_Use_ID,
  input  logic        IMem_Ready,
  output logic        STALL_IF,
  output logic        STALL_DUMMY,
  output logic        FLUSH_DUMMY,
  output logic        STALL_ID,
  output logic        FLUSH_ID,
  output logic        Redirect_Valid,
  output logic [31:0] Redirect_PC,
  output logic [31:0] Stall_Cycles,
  output logic [31:0] Flush_Count
);

  localparam logic [2:0] ST_RUN      = 3'd0;
  localparam logic [2:0] ST_LDSTALL  = 3'd1;
  localparam logic [2:0] ST_FLUSH    = 3'd2;
  localparam logic [2:0] ST_SYS_WAIT = 3'd3;
  localparam logic [2:0] ST_IMISS    = 3'd4;

  localparam logic [3:0] SYS_LOAD = 4'(SYS_MIN_CYCLES - 1);
  localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sticky_q, sticky_d;
  logic [31:0] rpc_q, rpc_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    state_d = ST_RUN;
    if (state_q == ST_SYS_WAIT) begin
      // A Done pulse on the final counted cycle is accepted as well as a sticky one.
      if (cnt_q == 4'd0 && (sticky_q || Syscall_Done_WB)) state_d = ST_RUN;
      else                                                state_d = ST_SYS_WAIT;
    end else if (Mispredict_EX)                       state_d = ST_FLUSH;
    else if (Syscall_ID)                              state_d = ST_SYS_WAIT;
    else if (Load_Use_ID && state_q == ST_RUN)        state_d = ST_LDSTALL;
    else if (!IMem_Ready)                             state_d = ST_IMISS;
    else                                              state_d = ST_RUN;
  end

  always_comb begin
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    rpc_d       = rpc_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (state_q != ST_SYS_WAIT && state_d == ST_SYS_WAIT) begin
      cnt_d    = SYS_LOAD;
      sticky_d = 1'b0;
    end else if (state_q == ST_SYS_WAIT) begin
      if (state_d != ST_SYS_WAIT) begin
        sticky_d = 1'b0;
      end else begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (Syscall_Done_WB) sticky_d = 1'b1;
      end
    end

    if (state_d == ST_FLUSH) begin
      rpc_d = Mispredict_PC_EX;
      if (flush_cnt_q != SAT_MAX) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    if (state_q != ST_RUN && stall_cnt_q != SAT_MAX) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_RUN;
      cnt_q       <= 4'd0;
      sticky_q    <= 1'b0;
      rpc_q       <= 32'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      rpc_q       <= rpc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Control strobes are decoded from the registered state only.
  always_comb begin
    STALL_IF       = 1'b0;
    STALL_DUMMY    = 1'b0;
    FLUSH_DUMMY    = 1'b0;
    STALL_ID       = 1'b0;
    FLUSH_ID       = 1'b0;
    Redirect_Valid = 1'b0;
    case (state_q)
      ST_LDSTALL, ST_SYS_WAIT: begin
        STALL_IF    = 1'b1;
        STALL_DUMMY = 1'b1;
        STALL_ID    = 1'b1;
        FLUSH_ID    = 1'b1;
      end
      ST_FLUSH: begin
        FLUSH_DUMMY    = 1'b1;
        FLUSH_ID       = 1'b1;
        Redirect_Valid = 1'b1;
      end
      ST_IMISS: begin
        STALL_IF    = 1'b1;
        FLUSH_DUMMY = 1'b1;
      end
      default: ;
    endcase
  end

  assign Redirect_PC  = rpc_q;
  assign Stall_Cycles = stall_cnt_q;
  assign Flush_Count  = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : directed scoreboard bench for pipe_hazard_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        Mispredict_EX = 1'b0;
  logic [31:0] Mispredict_PC_EX = 32'd0;
  logic        Syscall_ID = 1'b0;
  logic        Syscall_Done_WB = 1'b0;
  logic        Load_Use_ID = 1'b0;
  logic        IMem_Ready = 1'b1;
  logic        STALL_IF, STALL_DUMMY, FLUSH_DUMMY, STALL_ID, FLUSH_ID, Redirect_Valid;
  logic [31:0] Redirect_PC, Stall_Cycles, Flush_Count;

  pipe_hazard_ctrl #(.SYS_MIN_CYCLES(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .Mispredict_EX(Mispredict_EX), .Mispredict_PC_EX(Mispredict_PC_EX),
    .Syscall_ID(Syscall_ID), .Syscall_Done_WB(Syscall_Done_WB),
    .Load_Use_ID(Load_Use_ID), .IMem_Ready(IMem_Ready),
    .STALL_IF(STALL_IF), .STALL_DUMMY(STALL_DUMMY), .FLUSH_DUMMY(FLUSH_DUMMY),
    .STALL_ID(STALL_ID), .FLUSH_ID(FLUSH_ID), .Redirect_Valid(Redirect_Valid),
    .Redirect_PC(Redirect_PC), .Stall_Cycles(Stall_Cycles), .Flush_Count(Flush_Count)
  );

  always #5 CLK = ~CLK;

  // ctrl = {STALL_IF, STALL_DUMMY, FLUSH_DUMMY, STALL_ID, FLUSH_ID, Redirect_Valid}
  localparam logic [5:0] C_RUN   = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b110110;
  localparam logic [5:0] C_FLUSH = 6'b001011;
  localparam logic [5:0] C_IMISS = 6'b101000;

  typedef struct packed {
    logic [5:0]  ctrl;
    logic [31:0] rpc;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    logic [5:0] ctrl_obs;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
      return;
    end
    e = sb.pop_front();
    ctrl_obs = {STALL_IF, STALL_DUMMY, FLUSH_DUMMY, STALL_ID, FLUSH_ID, Redirect_Valid};
    cmp({tag, ".ctrl"}, {26'd0, ctrl_obs}, {26'd0, e.ctrl});
    cmp({tag, ".rpc"}, Redirect_PC, e.rpc);
    cmp({tag, ".stall_cycles"}, Stall_Cycles, e.sc);
    cmp({tag, ".flush_count"}, Flush_Count, e.fc);
  endtask

  // Called at a falling edge: drive inputs, record expectation, check after rising edge.
  task automatic step(input string tag, input logic mp, input logic [31:0] pc,
                      input logic sys, input logic done, input logic lu, input logic ir,
                      input logic [5:0] ctrl, input logic [31:0] rpc,
                      input logic [31:0] sc, input logic [31:0] fc);
    Mispredict_EX    = mp;
    Mispredict_PC_EX = pc;
    Syscall_ID       = sys;
    Syscall_Done_WB  = done;
    Load_Use_ID      = lu;
    IMem_Ready       = ir;
    sb.push_back('{ctrl, rpc, sc, fc});
    @(posedge CLK);
    #1;
    check_out(tag);
    @(negedge CLK);
  endtask

  initial begin
    @(negedge CLK);
    #1;
    sb.push_back('{C_RUN, 32'd0, 32'd0, 32'd0});
    check_out("reset");
    RESET = 1'b1;
    @(negedge CLK);

    // load-use held two cycles -> one LDSTALL
    step("idle",   0, 0, 0, 0, 0, 1, C_RUN,   32'd0, 0, 0);
    step("ld1",    0, 0, 0, 0, 1, 1, C_STALL, 32'd0, 0, 0);
    step("ld2",    0, 0, 0, 0, 1, 1, C_RUN,   32'd0, 1, 0);
    step("ld3",    0, 0, 0, 0, 0, 1, C_RUN,   32'd0, 1, 0);

    // mispredict, then back-to-back mispredicts
    step("mp1",    1, 32'h0040_0040, 0, 0, 0, 1, C_FLUSH, 32'h0040_0040, 1, 1);
    step("mp1b",   0, 0, 0, 0, 0, 1, C_RUN,   32'h0040_0040, 2, 1);
    step("mp2",    1, 32'h1111_0000, 0, 0, 0, 1, C_FLUSH, 32'h1111_0000, 2, 2);
    step("mp3",    1, 32'h2222_0004, 0, 0, 0, 1, C_FLUSH, 32'h2222_0004, 3, 3);
    step("mp3b",   0, 0, 0, 0, 0, 1, C_RUN,   32'h2222_0004, 4, 3);

    // mispredict and load-use together: flush wins, no LDSTALL until re-asserted in RUN
    step("mplu",   1, 32'h0000_0C00, 0, 0, 1, 1, C_FLUSH, 32'h0000_0C00, 4, 4);
    step("mplu2",  0, 0, 0, 0, 1, 1, C_RUN,   32'h0000_0C00, 5, 4);
    step("mplu3",  0, 0, 0, 0, 1, 1, C_STALL, 32'h0000_0C00, 5, 4);
    step("mplu4",  0, 0, 0, 0, 0, 1, C_RUN,   32'h0000_0C00, 6, 4);

    // four-cycle instruction miss
    for (int i = 0; i < 4; i++)
      step("imiss", 0, 0, 0, 0, 0, 0, C_IMISS, 32'h0000_0C00, 32'(6 + i), 4);
    step("imiss_end", 0, 0, 0, 0, 0, 1, C_RUN, 32'h0000_0C00, 10, 4);

    // syscall with early done; a mispredict inside SYS_WAIT is ignored
    step("sys1",   0, 0, 1, 0, 0, 1, C_STALL, 32'h0000_0C00, 10, 4);
    step("sys2",   0, 0, 0, 1, 0, 1, C_STALL, 32'h0000_0C00, 11, 4);
    step("sys3",   1, 32'hDEAD_BEEF, 0, 0, 0, 1, C_STALL, 32'h0000_0C00, 12, 4);
    step("sys4",   0, 0, 0, 0, 0, 1, C_RUN,   32'h0000_0C00, 13, 4);

    // syscall with late done: waits past the minimum
    step("sysl1",  0, 0, 1, 0, 0, 1, C_STALL, 32'h0000_0C00, 13, 4);
    step("sysl2",  0, 0, 0, 0, 0, 1, C_STALL, 32'h0000_0C00, 14, 4);
    step("sysl3",  0, 0, 0, 0, 0, 1, C_STALL, 32'h0000_0C00, 15, 4);
    step("sysl4",  0, 0, 0, 0, 0, 1, C_STALL, 32'h0000_0C00, 16, 4);
    step("sysl5",  0, 0, 0, 1, 0, 1, C_RUN,   32'h0000_0C00, 17, 4);

    // reset mid-SYS_WAIT after an early done
    step("sysr1",  0, 0, 1, 0, 0, 1, C_STALL, 32'h0000_0C00, 17, 4);
    step("sysr2",  0, 0, 0, 1, 0, 1, C_STALL, 32'h0000_0C00, 18, 4);
    Syscall_Done_WB = 1'b0;
    RESET = 1'b0;
    #1;
    sb.push_back('{C_RUN, 32'd0, 32'd0, 32'd0});
    check_out("async_reset");
    #2;
    RESET = 1'b1;
    @(negedge CLK);
    step("post_rst", 0, 0, 0, 0, 0, 1, C_RUN, 32'd0, 0, 0);

    // sticky done must have been forgotten: no early exit
    step("sysf1",  0, 0, 1, 0, 0, 1, C_STALL, 32'd0, 0, 0);
    step("sysf2",  0, 0, 0, 0, 0, 1, C_STALL, 32'd0, 1, 0);
    step("sysf3",  0, 0, 0, 0, 0, 1, C_STALL, 32'd0, 2, 0);
    step("sysf4",  0, 0, 0, 0, 0, 1, C_STALL, 32'd0, 3, 0);
    step("sysf5",  0, 0, 0, 1, 0, 1, C_RUN,   32'd0, 4, 0);

    // reset mid-FLUSH leaves no redirect behind
    step("mpr",    1, 32'h0BAD_0000, 0, 0, 0, 1, C_FLUSH, 32'h0BAD_0000, 4, 1);
    RESET = 1'b0;
    #1;
    sb.push_back('{C_RUN, 32'd0, 32'd0, 32'd0});
    check_out("reset_flush");
    #2;
    RESET = 1'b1;
    Mispredict_EX = 1'b0;
    @(negedge CLK);
    step("post_rst2", 0, 0, 0, 0, 0, 1, C_RUN, 32'd0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
